ui_button_press_decoder: RTL and testbench

UI_BUTTON_PRESS_DECODER -- requirements
Module: ui_button_press_decoder

---
 rtl/ui_pkg.sv | 28 ++
 rtl/ui_cycle_timer.sv | 36 +++
 rtl/ui_button_press_decoder.sv | 132 +++++++++++++
 tb/tb_ui_button_press_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - shared types and constants for the button press decoder
//
// Contents:
//   ui_press_state_t      : decoder FSM states (IDLE, PRESSED, LONG_HELD)
//   UI_LONG_CYCLES_DEF    : default long-press qualification time in clocks
//   UI_REPEAT_CYCLES_DEF  : default auto-repeat period in clocks
//   uiCounterWidth()      : width of a counter able to hold both periods

package ui_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } ui_press_state_t;

    localparam int UI_LONG_CYCLES_DEF   = 25_000_000;
    localparam int UI_REPEAT_CYCLES_DEF = 5_000_000;

    // One counter serves both the long-press and the repeat interval, so it
    // is sized for whichever of the two is larger.
    function automatic int uiCounterWidth(input int longCycles, input int repeatCycles);
        int maxCycles;
        maxCycles = (longCycles > repeatCycles) ? longCycles : repeatCycles;
        return $clog2(maxCycles + 1);
    endfunction

endpackage

// File: rtl/ui_cycle_timer.sv
// rtl/ui_cycle_timer.sv - clearable cycle counter with terminal-count compare
//
// Ports:
//   clock_50Mhz : in  clock
//   reset_n     : in  asynchronous active-low reset, clears the count
//   clear       : in  synchronous clear (wins over enable)
//   enable      : in  count up by one this cycle
//   tcValue     : in  terminal-count compare value
//   tc          : out high while the count equals tcValue

module ui_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock_50Mhz,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] tcValue,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign tc = (cnt == tcValue);

endmodule

// File: rtl/ui_button_press_decoder.sv
// rtl/ui_button_press_decoder.sv - classifies button presses as short, long and auto-repeat
//
// Ports:
//   clock_50Mhz  : in  sole clock
//   reset_n      : in  asynchronous active-low reset
//   button_n     : in  smoothed active-low button (0 = pressed), already glitch-free
//   short_press  : out one-cycle pulse, press released before qualifying as long
//   long_press   : out one-cycle pulse, press held for LONG_CYCLES
//   repeat_pulse : out one-cycle pulse every REPEAT_CYCLES while still held after long
//   held         : out level, high while in LONG_HELD
//   press_count  : out number of press starts, modulo 256

module ui_button_press_decoder
    import ui_pkg::*;
#(
    parameter int LONG_CYCLES   = UI_LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = UI_REPEAT_CYCLES_DEF
) (
    input  logic       clock_50Mhz,
    input  logic       reset_n,
    input  logic       button_n,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam int CNT_W = uiCounterWidth(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    ui_press_state_t  state;
    logic             btn_q;
    logic             timerClear;
    logic             timerEnable;
    logic [CNT_W-1:0] tcValue;
    logic             tc;

    // Timer control mirrors the FSM decisions below: the count restarts on
    // every press start, long qualification and repeat, and otherwise runs
    // while the button stays down.
    always_comb begin
        timerClear  = 1'b0;
        timerEnable = 1'b0;
        tcValue     = LONG_TC;
        case (state)
            IDLE: begin
                timerClear = ~btn_q;
            end
            PRESSED: begin
                if (!btn_q) begin
                    timerClear  = tc;
                    timerEnable = ~tc;
                end
            end
            LONG_HELD: begin
                tcValue = REPEAT_TC;
                if (!btn_q) begin
                    timerClear  = tc;
                    timerEnable = ~tc;
                end
            end
            default: begin
                timerClear = 1'b1;
            end
        endcase
    end

    ui_cycle_timer #(
        .WIDTH(CNT_W)
    ) cycleTimer (
        .clock_50Mhz(clock_50Mhz),
        .reset_n    (reset_n),
        .clear      (timerClear),
        .enable     (timerEnable),
        .tcValue    (tcValue),
        .tc         (tc)
    );

    // btn_q resets to "released" so a button already down at reset release
    // is seen as a fresh press two edges later.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            btn_q        <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
            press_count  <= 8'd0;
        end else begin
            btn_q        <= button_n;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!btn_q) begin
                        state       <= PRESSED;
                        press_count <= press_count + 8'd1;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over a coincident
                    // long-press threshold.
                    if (btn_q) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                    end else if (tc) begin
                        state      <= LONG_HELD;
                        long_press <= 1'b1;
                        held       <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (btn_q) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end else if (tc) begin
                        repeat_pulse <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ui_button_press_decoder.sv
// tb/tb_ui_button_press_decoder.sv - self-checking bench for ui_button_press_decoder

module tb_ui_button_press_decoder;

    localparam int LONG   = 20;
    localparam int REPEAT = 5;

    logic       clock_50Mhz;
    logic       reset_n;
    logic       button_n;
    logic       short_press;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    int nCompared = 0;
    int nFailed   = 0;
    int cyc       = 0;

    // Events are encoded as cycle*8 + kind:
    // 0 short, 1 long, 2 repeat, 3 held rise, 4 held fall, 5 press_count change
    int         obsQ[$];
    int         expQ[$];
    logic       prevHeld;
    logic [7:0] prevCount;
    int         modelCount;

    ui_button_press_decoder #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .button_n    (button_n),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .held        (held),
        .press_count (press_count)
    );

    initial clock_50Mhz = 1'b0;
    always #10 clock_50Mhz = ~clock_50Mhz;

    always @(posedge clock_50Mhz) cyc <= cyc + 1;

    // Reference model: a press whose button_n goes low right after edge c and
    // stays low for d cycles starts at edge p = c+2 and is released at edge p+d.
    task automatic model_press(input int c, input int d);
        int p;
        int l;
        p = c + 2;
        expQ.push_back(p * 8 + 5);
        modelCount = (modelCount + 1) % 256;
        if (d <= LONG) begin
            expQ.push_back((p + d) * 8 + 0);
        end else begin
            l = p + LONG;
            expQ.push_back(l * 8 + 1);
            expQ.push_back(l * 8 + 3);
            for (int k = 1; REPEAT * k < d - LONG; k++) begin
                expQ.push_back((l + REPEAT * k) * 8 + 2);
            end
            expQ.push_back((p + d) * 8 + 4);
        end
    endtask

    task automatic sample();
        @(negedge clock_50Mhz);
        if (short_press)               obsQ.push_back(cyc * 8 + 0);
        if (long_press)                obsQ.push_back(cyc * 8 + 1);
        if (repeat_pulse)              obsQ.push_back(cyc * 8 + 2);
        if (held && !prevHeld)         obsQ.push_back(cyc * 8 + 3);
        if (!held && prevHeld)         obsQ.push_back(cyc * 8 + 4);
        if (press_count !== prevCount) obsQ.push_back(cyc * 8 + 5);
        prevHeld  = held;
        prevCount = press_count;
    endtask

    task automatic restart_log();
        obsQ.delete();
        expQ.delete();
        prevHeld  = held;
        prevCount = press_count;
    endtask

    task automatic press(input int d, input int gap);
        button_n = 1'b0;
        model_press(cyc, d);
        repeat (d) sample();
        button_n = 1'b1;
        repeat (gap) sample();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        button_n = 1'b0;
        repeat (3) @(negedge clock_50Mhz);
        nCompared++;
        if ({short_press, long_press, repeat_pulse, held} !== 4'b0000) begin
            nFailed++;
            $display("FAIL reset_outputs: got %b want 0000", {short_press, long_press, repeat_pulse, held});
        end
        nCompared++;
        if (press_count !== 8'd0) begin
            nFailed++;
            $display("FAIL reset_count: got %0d want 0", press_count);
        end
        reset_n = 1'b1;
        restart_log();
        modelCount = 0;
        model_press(cyc, 10);
        sample();
        sample();
        nCompared++;
        if (press_count !== 8'd1) begin
            nFailed++;
            $display("FAIL reset_release_press: got %0d want 1", press_count);
        end
        repeat (8) sample();
        button_n = 1'b1;
        repeat (4) sample();
        nCompared++;
        if (obsQ.size() !== expQ.size()) begin
            nFailed++;
            $display("FAIL reset_events: got %0d events want %0d", obsQ.size(), expQ.size());
        end else begin
            for (int i = 0; i < obsQ.size(); i++) begin
                nCompared++;
                if (obsQ[i] !== expQ[i]) begin
                    nFailed++;
                    $display("FAIL reset_event[%0d]: got cyc %0d kind %0d want cyc %0d kind %0d",
                             i, obsQ[i] / 8, obsQ[i] % 8, expQ[i] / 8, expQ[i] % 8);
                end
            end
        end
    endtask

    // Runs a list of presses and checks the event log and the final count.
    task automatic run_and_check(input string name, input int durs[$], input int gaps[$]);
        restart_log();
        for (int i = 0; i < durs.size(); i++) press(durs[i], gaps[i]);
        nCompared++;
        if (obsQ.size() !== expQ.size()) begin
            nFailed++;
            $display("FAIL %s events: got %0d events want %0d", name, obsQ.size(), expQ.size());
        end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nCompared++;
            if (obsQ[i] !== expQ[i]) begin
                nFailed++;
                $display("FAIL %s event[%0d]: got cyc %0d kind %0d want cyc %0d kind %0d",
                         name, i, obsQ[i] / 8, obsQ[i] % 8, expQ[i] / 8, expQ[i] % 8);
                break;
            end
        end
        nCompared++;
        if (press_count !== 8'(modelCount)) begin
            nFailed++;
            $display("FAIL %s press_count: got %0d want %0d", name, press_count, modelCount);
        end
    endtask

    task automatic test_short();
        run_and_check("short", '{10}, '{4});
    endtask

    task automatic test_long();
        run_and_check("long", '{45}, '{4});
    endtask

    task automatic test_coincide();
        run_and_check("coincide", '{LONG, LONG + 1, LONG - 1}, '{4, 4, 4});
    endtask

    task automatic test_back_to_back();
        run_and_check("back_to_back", '{3, 25, 1, 30, 2}, '{1, 1, 1, 1, 4});
    endtask

    task automatic test_random();
        int durs[$];
        int gaps[$];
        for (int i = 0; i < 16; i++) begin
            durs.push_back(int'($urandom_range(45, 1)));
            gaps.push_back(int'($urandom_range(6, 1)));
        end
        gaps[15] = 4;
        run_and_check("random", durs, gaps);
    endtask

    task automatic test_reset_mid_held();
        button_n = 1'b0;
        repeat (30) @(negedge clock_50Mhz);
        nCompared++;
        if (held !== 1'b1) begin
            nFailed++;
            $display("FAIL mid_held_pre: got held %b want 1", held);
        end
        #2 reset_n = 1'b0;
        #1;
        nCompared++;
        if ({held, press_count} !== 9'd0) begin
            nFailed++;
            $display("FAIL mid_held_async: got held %b count %0d want 0 0", held, press_count);
        end
        button_n = 1'b1;
        @(negedge clock_50Mhz);
        reset_n = 1'b1;
        modelCount = 0;
        restart_log();
        repeat (10) sample();
        nCompared++;
        if (obsQ.size() !== 0 || press_count !== 8'd0) begin
            nFailed++;
            $display("FAIL mid_held_after: got %0d events count %0d want 0 0", obsQ.size(), press_count);
        end
    endtask

    task automatic test_wrap();
        int nShort;
        int durs[$];
        int gaps[$];
        reset_n = 1'b0;
        @(negedge clock_50Mhz);
        reset_n = 1'b1;
        modelCount = 0;
        for (int i = 0; i < 256; i++) begin
            durs.push_back(2);
            gaps.push_back(i == 255 ? 4 : 2);
        end
        run_and_check("wrap", durs, gaps);
        nShort = 0;
        foreach (obsQ[i]) if (obsQ[i] % 8 == 0) nShort++;
        nCompared++;
        if (nShort !== 256) begin
            nFailed++;
            $display("FAIL wrap_shorts: got %0d want 256", nShort);
        end
        nCompared++;
        if (press_count !== 8'd0) begin
            nFailed++;
            $display("FAIL wrap_zero: got %0d want 0", press_count);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        button_n   = 1'b1;
        prevHeld   = 1'b0;
        prevCount  = 8'd0;
        modelCount = 0;
        @(negedge clock_50Mhz);
        test_reset();
        test_short();
        test_long();
        test_coincide();
        test_back_to_back();
        test_random();
        test_reset_mid_held();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
